// File: rtl/nios2_dbg_jtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG debug initiator.
package nios2_dbg_jtag_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RESP
   } state_t;

   localparam logic [1:0] IR_MONITOR   = 2'b00;
   localparam logic [1:0] IR_BREAK     = 2'b01;
   localparam logic [1:0] IR_TRACEMEM  = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   localparam int DR_WIDTH_DEFAULT = 38;

endpackage

// File: rtl/nios2_dbg_tck_gen.sv
// Divided test clock with one-cycle-early rise/fall indications.
module nios2_dbg_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tck,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int CW = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
   localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
   localparam logic [CW-1:0] FALL_AT = CW'(2 * TCK_DIV - 1);

   logic [CW-1:0] cnt;

   // Pulses flag the cycle whose closing clk edge moves tck.
   assign rise_pulse = en && (cnt == RISE_AT);
   assign fall_pulse = en && (cnt == FALL_AT);

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt <= '0;
         tck <= 1'b0;
      end else if (cnt == FALL_AT) begin
         cnt <= '0;
         tck <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         if (cnt == RISE_AT) tck <= 1'b1;
      end
   end

endmodule

// File: rtl/nios2_debug_jtag_initiator.sv
// Command-driven virtual-JTAG master: runs UIR/CDR/SDR/UDR/RTI per command.
module nios2_debug_jtag_initiator
   import nios2_dbg_jtag_pkg::*;
#(
   parameter int TCK_DIV    = 2,
   parameter int IR_WIDTH   = 2,
   parameter int DR_WIDTH   = DR_WIDTH_DEFAULT,
   parameter int RTI_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int BW = $clog2(DR_WIDTH + 1);
   localparam int RW = $clog2(RTI_CYCLES + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH);
   localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

   state_t              state;
   logic [DR_WIDTH-1:0] shift;
   logic [DR_WIDTH-1:0] capture;
   logic [BW-1:0]       bit_cnt;
   logic [RW-1:0]       rti_cnt;
   logic                scan_en;
   logic                rise;
   logic                fall;

   assign scan_en = (state != ST_IDLE) && (state != ST_RESP);
   assign rsp_dr  = capture;

   nios2_dbg_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
      .clk        (clk),
      .reset      (reset),
      .en         (scan_en),
      .tck        (vji_tck),
      .rise_pulse (rise),
      .fall_pulse (fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_ir_out <= '0;
         vji_ir_in  <= '0;
         vji_tdi    <= 1'b0;
         vji_uir    <= 1'b0;
         vji_cdr    <= 1'b0;
         vji_sdr    <= 1'b0;
         vji_udr    <= 1'b0;
         vji_rti    <= 1'b0;
         shift      <= '0;
         capture    <= '0;
         bit_cnt    <= '0;
         rti_cnt    <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  vji_ir_in <= cmd_ir;
                  shift     <= cmd_dr;
                  vji_uir   <= 1'b1;
                  state     <= ST_UIR;
               end
            end
            ST_UIR: begin
               if (fall) begin
                  vji_uir <= 1'b0;
                  vji_cdr <= 1'b1;
                  state   <= ST_CDR;
               end
            end
            ST_CDR: begin
               if (fall) begin
                  vji_cdr <= 1'b0;
                  vji_sdr <= 1'b1;
                  vji_tdi <= shift[0];
                  state   <= ST_SDR;
               end
            end
            ST_SDR: begin
               // Capture fills from the top so bit 0 ends as the first sample.
               if (rise) begin
                  capture <= {vji_tdo, capture[DR_WIDTH-1:1]};
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if (fall) begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     vji_sdr <= 1'b0;
                     vji_udr <= 1'b1;
                     vji_tdi <= 1'b0;
                     state   <= ST_UDR;
                  end else begin
                     vji_tdi <= shift[0];
                  end
               end
            end
            ST_UDR: begin
               if (rise) rsp_ir_out <= vji_ir_out;
               if (fall) begin
                  vji_udr <= 1'b0;
                  vji_rti <= 1'b1;
                  state   <= ST_RTI;
               end
            end
            ST_RTI: begin
               if (fall) begin
                  if (rti_cnt == RTI_LAST) begin
                     rti_cnt   <= '0;
                     vji_rti   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= ST_RESP;
                  end else begin
                     rti_cnt <= rti_cnt + 1'b1;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_debug_jtag_initiator.sv
// Randomized bench for the virtual-JTAG initiator with a loopback slave model.
module tb_nios2_debug_jtag_initiator;
   import nios2_dbg_jtag_pkg::*;

   localparam int TCK_DIV = 2;
   localparam int DR_W    = 38;
   localparam int RTI     = 1;
   localparam int PER     = 2 * TCK_DIV;
   localparam int LAT     = 1 + PER * (3 + DR_W + RTI);

   logic            clk;
   logic            reset;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_ir;
   logic [DR_W-1:0] cmd_dr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DR_W-1:0] rsp_dr;
   logic [1:0]      rsp_ir_out;
   logic            vji_tck;
   logic            vji_tdi;
   logic            vji_tdo;
   logic [1:0]      vji_ir_in;
   logic [1:0]      vji_ir_out;
   logic            vji_uir;
   logic            vji_cdr;
   logic            vji_sdr;
   logic            vji_udr;
   logic            vji_rti;

   int checks;
   int errors;

   logic [DR_W-1:0] slave_sr;
   logic [DR_W-1:0] load_val;
   logic            load_pulse;

   nios2_debug_jtag_initiator #(
      .TCK_DIV(TCK_DIV), .IR_WIDTH(2), .DR_WIDTH(DR_W), .RTI_CYCLES(RTI)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
      .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
      .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
      .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
      .vji_udr(vji_udr), .vji_rti(vji_rti)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave scan chain: shifts tdi in at the top on each tck rise during SDR.
   assign vji_tdo = slave_sr[0];
   always @(posedge vji_tck or posedge load_pulse) begin
      if (load_pulse) slave_sr <= load_val;
      else if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[DR_W-1:1]};
   end

   function automatic logic [DR_W-1:0] rand_dr();
      logic [5:0]  hi;
      logic [31:0] lo;
      hi = 6'($urandom);
      lo = $urandom;
      return {hi, lo};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_slave(input logic [DR_W-1:0] v);
      load_val   = v;
      load_pulse = 1'b1;
      #1 load_pulse = 1'b0;
   endtask

   // Returns at the first sample after the accepting edge (cycle T+1).
   task automatic start_cmd(input logic [1:0] ir, input logic [DR_W-1:0] dr,
                            output bit ok);
      int n;
      cmd_ir    = ir;
      cmd_dr    = dr;
      cmd_valid = 1'b1;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      ok = (cmd_ready === 1'b1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 2000) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
      checks++;
      if ({rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
      end
      checks++;
      if ({rsp_dr, rsp_ir_out, vji_ir_in} !== '0) begin
         errors++;
         $display("FAIL reset_data: rsp_dr %h ir_out %b ir_in %b expected 0",
                  rsp_dr, rsp_ir_out, vji_ir_in);
      end
   endtask

   task automatic run_loopback(input string name, input logic [DR_W-1:0] pre,
                               input logic [DR_W-1:0] dr, input logic [1:0] ir,
                               input logic [1:0] iro);
      bit ok;
      int lat;
      load_slave(pre);
      vji_ir_out = iro;
      start_cmd(ir, dr, ok);
      checks++;
      if (!ok || vji_ir_in !== ir) begin
         errors++;
         $display("FAIL %s_accept: ok %0d ir_in %b expected %b", name, ok, vji_ir_in, ir);
      end
      wait_rsp(lat);
      checks++;
      if (lat != LAT) begin
         errors++;
         $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
      end
      checks++;
      if (rsp_dr !== pre) begin
         errors++;
         $display("FAIL %s_rsp_dr: got %h expected %h", name, rsp_dr, pre);
      end
      checks++;
      if (slave_sr !== dr) begin
         errors++;
         $display("FAIL %s_slave: got %h expected %h", name, slave_sr, dr);
      end
      checks++;
      if (rsp_ir_out !== iro) begin
         errors++;
         $display("FAIL %s_ir_out: got %b expected %b", name, rsp_ir_out, iro);
      end
      consume();
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s_release: cmd_ready %b rsp_valid %b expected 1 0",
                  name, cmd_ready, rsp_valid);
      end
   endtask

   task automatic test_loopback();
      run_loopback("loop_fixed", 38'h2A_5A5A_5A5A, 38'h15_1234_5678,
                   IR_MONITOR, 2'b10);
      for (int i = 0; i < 3; i++)
         run_loopback("loop_rand", rand_dr(), rand_dr(),
                      2'($urandom), 2'($urandom));
   endtask

   task automatic test_strobes();
      bit ok;
      int n;
      int w[5];
      int first[5];
      int rises;
      int viol;
      logic prev_tck;
      logic [4:0] s;
      int exp_first[5];
      for (int k = 0; k < 5; k++) begin
         w[k] = 0;
         first[k] = 0;
      end
      exp_first[0] = 1;
      exp_first[1] = 1 + PER;
      exp_first[2] = 1 + 2 * PER;
      exp_first[3] = 1 + (2 + DR_W) * PER;
      exp_first[4] = 1 + (3 + DR_W) * PER;
      rises = 0;
      viol = 0;
      prev_tck = 1'b0;
      load_slave(rand_dr());
      start_cmd(IR_TRACEMEM, rand_dr(), ok);
      checks++;
      if (!ok || vji_ir_in !== IR_TRACEMEM) begin
         errors++;
         $display("FAIL strobe_ir_in: got %b expected %b", vji_ir_in, IR_TRACEMEM);
      end
      n = 1;
      while (rsp_valid !== 1'b1 && n < 400) begin
         s = {vji_rti, vji_udr, vji_sdr, vji_cdr, vji_uir};
         if ($countones(s) > 1) viol++;
         for (int k = 0; k < 5; k++)
            if (s[k]) begin
               w[k]++;
               if (first[k] == 0) first[k] = n;
            end
         if (vji_tck === 1'b1 && prev_tck === 1'b0 && vji_sdr === 1'b1) rises++;
         prev_tck = vji_tck;
         tick();
         n++;
      end
      checks++;
      if (w[0] != PER || w[1] != PER || w[3] != PER || w[4] != RTI * PER) begin
         errors++;
         $display("FAIL strobe_widths: uir %0d cdr %0d udr %0d rti %0d expected %0d %0d %0d %0d",
                  w[0], w[1], w[3], w[4], PER, PER, PER, RTI * PER);
      end
      checks++;
      if (w[2] != DR_W * PER || rises != DR_W) begin
         errors++;
         $display("FAIL strobe_sdr: width %0d rises %0d expected %0d %0d",
                  w[2], rises, DR_W * PER, DR_W);
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL strobe_onehot: got %0d overlaps expected 0", viol);
      end
      checks++;
      if (first != exp_first) begin
         errors++;
         $display("FAIL strobe_order: got %0d %0d %0d %0d %0d expected %0d %0d %0d %0d %0d",
                  first[0], first[1], first[2], first[3], first[4],
                  exp_first[0], exp_first[1], exp_first[2], exp_first[3], exp_first[4]);
      end
      consume();
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      int bad;
      logic [DR_W-1:0] pre;
      logic [DR_W-1:0] hold;
      pre = rand_dr();
      bad = 0;
      load_slave(pre);
      start_cmd(IR_BREAK, rand_dr(), ok);
      wait_rsp(lat);
      hold = rsp_dr;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_dr !== hold || cmd_ready !== 1'b0 || vji_tck !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0 || hold !== pre) begin
         errors++;
         $display("FAIL bp_stall: bad %0d rsp_dr %h expected 0 %h", bad, hold, pre);
      end
      load_slave(rand_dr());
      cmd_ir    = IR_TRACECTRL;
      cmd_dr    = rand_dr();
      cmd_valid = 1'b1;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: cmd_ready %b rsp_valid %b expected 1 0", cmd_ready, rsp_valid);
      end
      tick();
      cmd_valid = 1'b0;
      checks++;
      if (cmd_ready !== 1'b0 || vji_ir_in !== IR_TRACECTRL) begin
         errors++;
         $display("FAIL bp_second_accept: cmd_ready %b ir_in %b expected 0 %b",
                  cmd_ready, vji_ir_in, IR_TRACECTRL);
      end
      wait_rsp(lat);
      checks++;
      if (lat != LAT) begin
         errors++;
         $display("FAIL bp_second_latency: got %0d expected %0d", lat, LAT);
      end
      consume();
   endtask

   task automatic test_reset_mid_scan();
      bit ok;
      int n;
      int rises;
      int seen;
      logic prev_tck;
      rises = 0;
      n = 0;
      prev_tck = 1'b0;
      load_slave(rand_dr());
      start_cmd(IR_MONITOR, rand_dr(), ok);
      while (rises < 20 && n < 400) begin
         tick();
         n++;
         if (vji_tck === 1'b1 && prev_tck === 1'b0 && vji_sdr === 1'b1) rises++;
         prev_tck = vji_tck;
      end
      checks++;
      if (rises != 20) begin
         errors++;
         $display("FAIL rst_reach_bit20: got %0d expected 20", rises);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tck, rsp_valid} !== 7'b0 ||
          cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_abort: strobes/tck/rsp %b cmd_ready %b expected 0000000 1",
                  {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tck, rsp_valid}, cmd_ready);
      end
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (rsp_valid === 1'b1 || vji_tck === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_no_rsp: got %0d active cycles expected 0", seen);
      end
      run_loopback("rst_after", rand_dr(), rand_dr(), 2'($urandom), 2'($urandom));
   endtask

   task automatic test_ir_out();
      bit ok;
      int n;
      int lat;
      vji_ir_out = 2'b01;
      load_slave(rand_dr());
      start_cmd(IR_BREAK, rand_dr(), ok);
      n = 0;
      while (vji_udr !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      while (vji_udr === 1'b1 && n < 400) begin
         tick();
         n++;
      end
      vji_ir_out = 2'b11;
      wait_rsp(lat);
      checks++;
      if (rsp_ir_out !== 2'b01) begin
         errors++;
         $display("FAIL ir_out_capture: got %b expected 01", rsp_ir_out);
      end
      repeat (5) tick();
      checks++;
      if (rsp_ir_out !== 2'b01) begin
         errors++;
         $display("FAIL ir_out_hold: got %b expected 01", rsp_ir_out);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      localparam int N = 4;
      logic [DR_W-1:0] dr[N];
      logic [DR_W-1:0] exp_q[$];
      logic [DR_W-1:0] got[$];
      int acc[$];
      int cyc;
      int na;
      logic prev_ready;
      logic [DR_W-1:0] pre;
      pre = rand_dr();
      for (int i = 0; i < N; i++) dr[i] = rand_dr();
      exp_q.push_back(pre);
      for (int i = 0; i < N - 1; i++) exp_q.push_back(dr[i]);
      load_slave(pre);
      rsp_ready  = 1'b1;
      cmd_ir     = 2'($urandom);
      cmd_dr     = dr[0];
      cmd_valid  = 1'b1;
      prev_ready = cmd_ready;
      na  = 0;
      cyc = 0;
      while (got.size() < N && cyc < 2000) begin
         tick();
         cyc++;
         if (prev_ready === 1'b1 && cmd_ready === 1'b0) begin
            acc.push_back(cyc);
            na++;
            if (na < N) begin
               cmd_dr = dr[na];
               cmd_ir = 2'($urandom);
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (rsp_valid === 1'b1) got.push_back(rsp_dr);
         prev_ready = cmd_ready;
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      checks++;
      if (acc.size() != N || got.size() != N) begin
         errors++;
         $display("FAIL b2b_count: accepts %0d responses %0d expected %0d",
                  acc.size(), got.size(), N);
      end
      for (int i = 1; i < acc.size(); i++) begin
         checks++;
         if (acc[i] - acc[i-1] != LAT + 1) begin
            errors++;
            $display("FAIL b2b_interval: got %0d expected %0d", acc[i] - acc[i-1], LAT + 1);
         end
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_ir     = '0;
      cmd_dr     = '0;
      rsp_ready  = 1'b0;
      vji_ir_out = '0;
      load_val   = '0;
      load_pulse = 1'b0;
      tick();
      test_reset();
      test_loopback();
      test_strobes();
      test_backpressure();
      test_reset_mid_scan();
      test_ir_out();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
